// File: rtl/key_conditioner_if.sv
// Raw board keys into the conditioner and the clean rocket commands out of it.
interface key_conditioner_if;
  logic key_left_n;
  logic key_right_n;
  logic key_start_n;
  logic left;
  logic right;
  logic start;

  modport master (
    output key_left_n, key_right_n, key_start_n,
    input  left, right, start
  );

  modport slave (
    input  key_left_n, key_right_n, key_start_n,
    output left, right, start
  );
endinterface

// File: rtl/key_conditioner.sv
// Key conditioner: sync + debounce of three active-low keys, start level, left/right move pulses.
// Build option KEY_AUTOREPEAT_EN: held direction keys auto-repeat; otherwise one pulse per press.
module key_conditioner #(
  parameter int unsigned DEBOUNCE_CYCLES = 500000,
  parameter int unsigned REPEAT_DELAY    = 25000000,
  parameter int unsigned REPEAT_PERIOD   = 5000000,
  parameter int unsigned CNT_W           = 25
) (
  input logic              clk,
  input logic              reset,
  key_conditioner_if.slave kif
);
  localparam int unsigned NK  = 3;
  localparam int unsigned K_L = 0;
  localparam int unsigned K_R = 1;
  localparam int unsigned K_S = 2;
  localparam int unsigned MAX_CYC_A = (DEBOUNCE_CYCLES > REPEAT_DELAY) ? DEBOUNCE_CYCLES : REPEAT_DELAY;
  localparam int unsigned MAX_CYC   = (MAX_CYC_A > REPEAT_PERIOD) ? MAX_CYC_A : REPEAT_PERIOD;

  // Synchronisers reset to 0 (reads as pressed), so debounce must outlast the 2-cycle refill.
  if (DEBOUNCE_CYCLES < 3 || REPEAT_DELAY < 1 || REPEAT_PERIOD < 1 ||
      CNT_W < $clog2(MAX_CYC)) begin : g_bad_cfg
    $error("key_conditioner: invalid parameter set");
  end

  logic [NK-1:0]    raw, sync1, sync2, ks, db;
  logic [1:0]       db_q;
  logic [CNT_W-1:0] dcnt [NK];
  logic             start_q, left_q, right_q;
  logic             press_l, press_r, rel_l, rel_r;
  logic             other_press, dir_rel;
  logic [1:0]       state, state_nxt;
  logic             dir, dir_nxt, left_nxt, right_nxt;

  assign raw = {kif.key_start_n, kif.key_right_n, kif.key_left_n};
  assign ks  = ~sync2;

  // Two-flop synchroniser and per-key debounce counter
  always_ff @(posedge clk) begin
    if (reset) begin
      sync1   <= '0;
      sync2   <= '0;
      db      <= '0;
      db_q    <= '0;
      start_q <= 1'b0;
      for (int i = 0; i < NK; i++) dcnt[i] <= '0;
    end else begin
      sync1   <= raw;
      sync2   <= sync1;
      db_q    <= db[1:0];
      start_q <= db[K_S];
      for (int i = 0; i < NK; i++) begin
        if (ks[i] == db[i]) begin
          dcnt[i] <= '0;
        end else if (dcnt[i] == CNT_W'(DEBOUNCE_CYCLES - 1)) begin
          db[i]   <= ks[i];
          dcnt[i] <= '0;
        end else begin
          dcnt[i] <= dcnt[i] + CNT_W'(1);
        end
      end
    end
  end

  assign press_l     = db[K_L] & ~db_q[K_L];
  assign press_r     = db[K_R] & ~db_q[K_R];
  assign rel_l       = ~db[K_L];
  assign rel_r       = ~db[K_R];
  assign other_press = dir ? press_l : press_r;
  assign dir_rel     = dir ? rel_r : rel_l;

`ifdef KEY_AUTOREPEAT_EN
  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_DELAY  = 2'd1;
  localparam logic [1:0] S_REPEAT = 2'd2;

  logic [CNT_W-1:0] rcnt, rcnt_nxt, rlimit;

  // Move FSM with auto-repeat; release beats a new edge, a new edge beats a repeat
  always_comb begin
    state_nxt = state;
    dir_nxt   = dir;
    rcnt_nxt  = rcnt;
    left_nxt  = 1'b0;
    right_nxt = 1'b0;
    rlimit    = (state == S_DELAY) ? CNT_W'(REPEAT_DELAY - 1) : CNT_W'(REPEAT_PERIOD - 1);
    case (state)
      S_IDLE: begin
        rcnt_nxt = '0;
        if (press_l || press_r) begin
          left_nxt  = press_l;
          right_nxt = !press_l;
          dir_nxt   = !press_l;
          state_nxt = S_DELAY;
        end
      end
      S_DELAY, S_REPEAT: begin
        if (dir_rel) begin
          state_nxt = S_IDLE;
        end else if (other_press) begin
          left_nxt  = dir;
          right_nxt = !dir;
          dir_nxt   = !dir;
          rcnt_nxt  = '0;
          state_nxt = S_DELAY;
        end else if (rcnt == rlimit) begin
          left_nxt  = !dir;
          right_nxt = dir;
          rcnt_nxt  = '0;
          state_nxt = S_REPEAT;
        end else begin
          rcnt_nxt = rcnt + CNT_W'(1);
        end
      end
      default: state_nxt = S_IDLE;
    endcase
  end
`else
  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_HELD = 2'd1;

  // Move FSM, one pulse per debounced press
  always_comb begin
    state_nxt = state;
    dir_nxt   = dir;
    left_nxt  = 1'b0;
    right_nxt = 1'b0;
    case (state)
      S_IDLE: begin
        if (press_l || press_r) begin
          left_nxt  = press_l;
          right_nxt = !press_l;
          dir_nxt   = !press_l;
          state_nxt = S_HELD;
        end
      end
      S_HELD: begin
        if (dir_rel) begin
          state_nxt = S_IDLE;
        end else if (other_press) begin
          left_nxt  = dir;
          right_nxt = !dir;
          dir_nxt   = !dir;
        end
      end
      default: state_nxt = S_IDLE;
    endcase
  end
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= S_IDLE;
      dir     <= 1'b0;
      left_q  <= 1'b0;
      right_q <= 1'b0;
`ifdef KEY_AUTOREPEAT_EN
      rcnt    <= '0;
`endif
    end else begin
      state   <= state_nxt;
      dir     <= dir_nxt;
      left_q  <= left_nxt;
      right_q <= right_nxt;
`ifdef KEY_AUTOREPEAT_EN
      rcnt    <= rcnt_nxt;
`endif
    end
  end

  assign kif.left  = left_q;
  assign kif.right = right_q;
  assign kif.start = start_q;
endmodule

// File: tb/tb_key_conditioner.sv
// Bench for key_conditioner: vector table plus hand sequences, expected pulses held in a scoreboard queue.
module tb_key_conditioner;
  localparam int unsigned DEB = 4;
  localparam int unsigned RD  = 8;
  localparam int unsigned RP  = 3;
  localparam int          LAT = 7;

  typedef struct { int at; bit is_right; } pulse_t;
  typedef struct { logic [1:0] sel; int hold; int gap; int n_rep; int n_one; } vec_t;

  logic   clk   = 1'b0;
  logic   reset = 1'b1;
  int     cyc = 0;
  int     nvec = 0;
  int     nmis = 0;
  int     n_pulses = 0;
  pulse_t exp_q[$];
  vec_t   vecs[9];

  key_conditioner_if kif();

  key_conditioner #(
    .DEBOUNCE_CYCLES(DEB),
    .REPEAT_DELAY(RD),
    .REPEAT_PERIOD(RP),
    .CNT_W(25)
  ) dut (
    .clk(clk),
    .reset(reset),
    .kif(kif)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input int act, input int exp);
    nvec++;
    if (act != exp) begin
      nmis++;
      $display("FAIL %s at cycle %0d: got %0d, expected %0d", name, cyc, act, exp);
    end
  endtask

  // One clock; any pulse seen is matched against the scoreboard head
  task automatic tick();
    pulse_t p;
    @(negedge clk);
    if (kif.left === 1'b1 || kif.right === 1'b1) begin
      n_pulses++;
      check("left_right_exclusive", int'(kif.left & kif.right), 0);
      if (exp_q.size() == 0) begin
        check("unexpected_pulse", int'(kif.right), -1);
      end else begin
        p = exp_q.pop_front();
        check("pulse_cycle", cyc, p.at);
        check("pulse_is_right", int'(kif.right), int'(p.is_right));
      end
    end
  endtask

  task automatic ticks(input int n);
    repeat (n) tick();
  endtask

  // Pulses of one direction from t0 while the debounced key is still held at edge 'last'
  task automatic push_train(input bit r, input int t0, input int last);
    pulse_t p;
    int t = t0;
    while (t <= last) begin
      p.at = t;
      p.is_right = r;
      exp_q.push_back(p);
`ifdef KEY_AUTOREPEAT_EN
      t += (t == t0) ? int'(RD) : int'(RP);
`else
      t = last + 1;
`endif
    end
  endtask

  task automatic drain(input string name);
    check({"missing_pulses_", name}, exp_q.size(), 0);
    exp_q.delete();
  endtask

  task automatic set_keys(input logic l, input logic r, input logic s);
    kif.key_left_n  = l;
    kif.key_right_n = r;
    kif.key_start_n = s;
  endtask

  initial begin
    int c, c2, base;
    vecs[0] = '{2'd1,  3, 12, 0, 0};
    vecs[1] = '{2'd1,  4, 12, 1, 1};
    vecs[2] = '{2'd2,  3, 12, 0, 0};
    vecs[3] = '{2'd2,  4, 12, 1, 1};
    vecs[4] = '{2'd1,  8, 14, 1, 1};
    vecs[5] = '{2'd1,  9, 14, 2, 1};
    vecs[6] = '{2'd1, 20, 14, 5, 1};
    vecs[7] = '{2'd2, 30, 14, 9, 1};
    vecs[8] = '{2'd3, 10, 14, 2, 1};

    // Reset held with every key pressed
    set_keys(1'b0, 1'b0, 1'b0);
    reset = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("reset_left",  int'(kif.left),  0);
      check("reset_right", int'(kif.right), 0);
      check("reset_start", int'(kif.start), 0);
    end
    reset = 1'b0;
    c = cyc;
    push_train(1'b0, c + 5, c + 12 + LAT - 1);
    for (int i = 0; i < 12; i++) begin
      tick();
      check("start_after_reset", int'(kif.start), int'(cyc >= c + 5));
    end
    set_keys(1'b1, 1'b1, 1'b1);
    c = cyc;
    for (int i = 0; i < 10; i++) begin
      tick();
      check("start_release", int'(kif.start), int'(cyc < c + LAT));
    end
    ticks(4);
    drain("reset_hold");

    foreach (vecs[i]) begin
      base = n_pulses;
      set_keys(!vecs[i].sel[0], !vecs[i].sel[1], 1'b1);
      c = cyc;
      if (vecs[i].hold >= int'(DEB))
        push_train(!vecs[i].sel[0], c + LAT, c + vecs[i].hold + LAT - 1);
      ticks(vecs[i].hold);
      set_keys(1'b1, 1'b1, 1'b1);
      ticks(vecs[i].gap);
`ifdef KEY_AUTOREPEAT_EN
      check("pulse_count", n_pulses - base, vecs[i].n_rep);
`else
      check("pulse_count", n_pulses - base, vecs[i].n_one);
`endif
      drain("table");
    end

    // Bouncing left key, then a clean press
    for (int i = 0; i < 5; i++) begin
      set_keys(1'b0, 1'b1, 1'b1);
      ticks(2);
      set_keys(1'b1, 1'b1, 1'b1);
      ticks(2);
    end
    set_keys(1'b0, 1'b1, 1'b1);
    c = cyc;
    push_train(1'b0, c + LAT, c + 10 + LAT - 1);
    ticks(10);
    set_keys(1'b1, 1'b1, 1'b1);
    ticks(12);
    drain("bounce");

    // Start level, no move pulses
    set_keys(1'b1, 1'b1, 1'b0);
    c = cyc;
    for (int i = 0; i < 10; i++) begin
      tick();
      check("start_press", int'(kif.start), int'(cyc >= c + LAT));
    end
    set_keys(1'b1, 1'b1, 1'b1);
    c = cyc;
    for (int i = 0; i < 10; i++) begin
      tick();
      check("start_hold_release", int'(kif.start), int'(cyc < c + LAT));
    end
    drain("start");

    // Right pressed while left held: switch direction, then release right with left still held
    set_keys(1'b0, 1'b1, 1'b1);
    c = cyc;
    push_train(1'b0, c + LAT, c + 5 + LAT - 1);
    ticks(5);
    set_keys(1'b0, 1'b0, 1'b1);
    c2 = cyc;
    push_train(1'b1, c2 + LAT, c2 + 20 + LAT - 1);
    ticks(20);
    set_keys(1'b0, 1'b1, 1'b1);
    ticks(10);
    set_keys(1'b1, 1'b1, 1'b1);
    ticks(12);
    drain("switch");

    // Same-edge press, then left released while right held
    set_keys(1'b0, 1'b0, 1'b1);
    c = cyc;
    push_train(1'b0, c + LAT, c + 8 + LAT - 1);
    ticks(8);
    set_keys(1'b1, 1'b0, 1'b1);
    ticks(14);
    set_keys(1'b1, 1'b1, 1'b1);
    ticks(12);
    drain("left_release_right_held");

    // Reset mid-hold: held key re-debounces and pulses again
    set_keys(1'b0, 1'b1, 1'b1);
    c = cyc;
    push_train(1'b0, c + LAT, c + LAT);
    ticks(10);
    reset = 1'b1;
    for (int i = 0; i < 2; i++) begin
      tick();
      check("midreset_left", int'(kif.left), 0);
    end
    reset = 1'b0;
    c = cyc;
    push_train(1'b0, c + 5, c + 12 + LAT - 1);
    ticks(12);
    set_keys(1'b1, 1'b1, 1'b1);
    ticks(14);
    drain("mid_reset");

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
    $finish;
  end
endmodule
